// File: rtl/nd_2to1.sv
// Two-input 4-phase message merger: per-input FIFOs feed one registered 4-phase output channel.
// Latency: input written at edge t, snd0_req high after t+1 at the earliest. Full FIFO stalls rcvK_ack low.
// Build option ND_2TO1_RR_ARB_EN selects round-robin arbitration; otherwise input 0 has fixed priority.
module nd_2to1 #(
    parameter int FSZ = 2,
    parameter int ASZ = 8,
    parameter int DSZ = 8,
    parameter int RSZ = 4
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack,
    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red
);
    localparam int PW = (FSZ > 1) ? $clog2(FSZ) : 1;
    localparam int CW = $clog2(FSZ + 1);

    typedef struct packed {
        logic [ASZ-1:0] src;
        logic [ASZ-1:0] dst;
        logic [DSZ-1:0] dat;
        logic [RSZ-1:0] red;
    } msg_t;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    msg_t          mem_q [2][FSZ];
    logic [PW-1:0] head_q [2], head_d [2], tail_q [2], tail_d [2];
    logic [CW-1:0] cnt_q [2], cnt_d [2];
    logic [1:0]    ack_q, ack_d, req_in, wr_en, rd_en, ne;
    msg_t          msg_in [2];
    msg_t          out_q, out_d, head_msg;
    state_t        state_q, state_d;
    logic          snd_req_q, snd_req_d, ready_q, ready_d, win, pop;
`ifdef ND_2TO1_RR_ARB_EN
    logic          prio_q, prio_d;
`endif

    assign req_in    = {rcv1_req, rcv0_req};
    assign msg_in[0] = '{rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign msg_in[1] = '{rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};
    assign ne        = {cnt_q[1] != '0, cnt_q[0] != '0};

`ifdef ND_2TO1_RR_ARB_EN
    // prio_q holds the input favoured on contention, i.e. the one that did not win last.
    assign win = (ne[0] && ne[1]) ? prio_q : ne[1];
`else
    assign win = !ne[0];
`endif
    assign pop      = (state_q == IDLE) && (ne != 2'b00);
    assign rd_en    = pop ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign head_msg = mem_q[win][head_q[win]];

    always_comb begin
        ack_d = ack_q;
        wr_en = 2'b00;
        for (int k = 0; k < 2; k++) begin
            // A pop in the same cycle frees a slot, so a full FIFO may still accept.
            wr_en[k] = req_in[k] && !ack_q[k] && ((cnt_q[k] != CW'(FSZ)) || rd_en[k]);
            if (!req_in[k])
                ack_d[k] = 1'b0;
            else if (wr_en[k])
                ack_d[k] = 1'b1;
            tail_d[k] = tail_q[k];
            head_d[k] = head_q[k];
            if (wr_en[k])
                tail_d[k] = (tail_q[k] == PW'(FSZ - 1)) ? '0 : tail_q[k] + 1'b1;
            if (rd_en[k])
                head_d[k] = (head_q[k] == PW'(FSZ - 1)) ? '0 : head_q[k] + 1'b1;
            cnt_d[k] = cnt_q[k] + CW'(wr_en[k]) - CW'(rd_en[k]);
        end
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        snd_req_d = snd_req_q;
        ready_d   = 1'b1;
`ifdef ND_2TO1_RR_ARB_EN
        prio_d    = pop ? !win : prio_q;
`endif
        case (state_q)
            IDLE: if (pop) begin
                out_d     = head_msg;
                snd_req_d = 1'b1;
                state_d   = SEND;
            end
            SEND: if (snd0_ack) begin
                snd_req_d = 1'b0;
                state_d   = WAIT;
            end
            WAIT: if (!snd0_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gch_clk) begin
        for (int k = 0; k < 2; k++)
            if (wr_en[k]) mem_q[k][tail_q[k]] <= msg_in[k];
    end

    always_ff @(posedge gch_clk) begin
        if (!gch_reset) begin
            state_q   <= IDLE;
            out_q     <= '0;
            snd_req_q <= 1'b0;
            ready_q   <= 1'b0;
            ack_q     <= 2'b00;
`ifdef ND_2TO1_RR_ARB_EN
            prio_q    <= 1'b0;
`endif
            for (int k = 0; k < 2; k++) begin
                head_q[k] <= '0;
                tail_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            snd_req_q <= snd_req_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
`ifdef ND_2TO1_RR_ARB_EN
            prio_q    <= prio_d;
`endif
            for (int k = 0; k < 2; k++) begin
                head_q[k] <= head_d[k];
                tail_q[k] <= tail_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign gch_ready = ready_q;
    assign rcv0_ack  = ack_q[0];
    assign rcv1_ack  = ack_q[1];
    assign snd0_req  = snd_req_q;
    assign snd0_src  = out_q.src;
    assign snd0_dst  = out_q.dst;
    assign snd0_dat  = out_q.dat;
    assign snd0_red  = out_q.red;
endmodule
